// File: rtl/dma_pkg.sv
// Shared widths and types for the DMA host-read path.
// Imported by the scheduler and the requester-ID FIFO.
package dma_pkg;

    localparam int DMA_ADDR_W = 16;
    localparam int DMA_TILE_W = 18 * 16;

    typedef logic [DMA_TILE_W-1:0] dma_tile_t;

    function automatic int req_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dma_tag_fifo.sv
// In-order tag FIFO with simultaneous push/pop, occupancy count and empty flag.
// A push into a full FIFO is accepted only when a pop frees a slot the same cycle.
module dma_tag_fifo
    import dma_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dma_read_scheduler.sv
// Round-robin host-read arbiter with credit cap and in-order response routing.
// Each issued read's requester ID rides a tag FIFO until its response returns.
module dma_read_scheduler
    import dma_pkg::*;
#(
    parameter int N_REQ           = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_W          = DMA_ADDR_W,
    parameter int TILE_W          = DMA_TILE_W,
    parameter int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall_issue,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]       rdq_data,
    output logic                    rdq_we,
    input  logic                    rdq_full,
    input  logic                    resp_valid,
    input  logic [TILE_W-1:0]       resp_data,
    output logic [N_REQ-1:0]        resp_out_valid,
    output logic [TILE_W-1:0]       resp_out_data,
    output logic [CW-1:0]           outstanding,
    output logic                    idle,
    output logic                    err_unexpected_resp
);

    localparam int IDW = req_id_w(N_REQ);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] cand;
    logic [IDW-1:0] head_id;
    logic           found;
    logic           grant;
    logic           fifo_empty;
    logic           fifo_full;

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDW'((int'(ptr) + k) % N_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign grant = found && !stall_issue && !rdq_full
                && (outstanding < CW'(MAX_OUTSTANDING));

    assign req_ready = grant ? (N_REQ'(1) << winner) : '0;
    assign idle      = (outstanding == '0) && !rdq_we;

    dma_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .W     (IDW),
        .CW    (CW)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (grant),
        .push_data (winner),
        .pop       (resp_valid),
        .pop_data  (head_id),
        .count     (outstanding),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr                 <= IDW'(N_REQ - 1);
            rdq_we              <= 1'b0;
            rdq_data            <= '0;
            resp_out_valid      <= '0;
            resp_out_data       <= '0;
            err_unexpected_resp <= 1'b0;
        end else begin
            rdq_we         <= grant;
            resp_out_valid <= '0;
            if (grant) begin
                ptr      <= winner;
                rdq_data <= req_addr[int'(winner)*ADDR_W +: ADDR_W];
            end
            if (resp_valid) begin
                if (fifo_empty) begin
                    err_unexpected_resp <= 1'b1;
                end else begin
                    resp_out_valid <= N_REQ'(1) << head_id;
                    resp_out_data  <= resp_data;
                end
            end
        end
    end

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_dma_read_scheduler.sv
// Directed bench for dma_read_scheduler with a queue-based scoreboard.
// Expected issues and deliveries are queued at stimulus time and popped on output.
module tb_dma_read_scheduler;

    logic         clk;
    logic         reset;
    logic         stall_issue;
    logic [3:0]   req_valid;
    logic [63:0]  req_addr;
    logic [3:0]   req_ready;
    logic [15:0]  rdq_data;
    logic         rdq_we;
    logic         rdq_full;
    logic         resp_valid;
    logic [287:0] resp_data;
    logic [3:0]   resp_out_valid;
    logic [287:0] resp_out_data;
    logic [2:0]   outstanding;
    logic         idle;
    logic         err_unexpected_resp;

    int checks   = 0;
    int failures = 0;

    logic [15:0]  rdq_q[$];
    logic [3:0]   resp_v_q[$];
    logic [287:0] resp_d_q[$];
    int           id_q[$];

    dma_read_scheduler dut (
        .clk                 (clk),
        .reset               (reset),
        .stall_issue         (stall_issue),
        .req_valid           (req_valid),
        .req_addr            (req_addr),
        .req_ready           (req_ready),
        .rdq_data            (rdq_data),
        .rdq_we              (rdq_we),
        .rdq_full            (rdq_full),
        .resp_valid          (resp_valid),
        .resp_data           (resp_data),
        .resp_out_valid      (resp_out_valid),
        .resp_out_data       (resp_out_data),
        .outstanding         (outstanding),
        .idle                (idle),
        .err_unexpected_resp (err_unexpected_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [287:0] got,
                       input logic [287:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_addr(input logic [15:0] a0, input logic [15:0] a1,
                            input logic [15:0] a2, input logic [15:0] a3);
        req_addr = {a3, a2, a1, a0};
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        stall_issue = 1'b0;
        req_valid   = '0;
        rdq_full    = 1'b0;
        resp_valid  = 1'b0;
        resp_data   = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        rdq_q.delete();
        resp_v_q.delete();
        resp_d_q.delete();
        id_q.delete();
        chk("rst_req_ready", 288'(req_ready), 288'(0));
        chk("rst_rdq_we", 288'(rdq_we), 288'(0));
        chk("rst_rdq_data", 288'(rdq_data), 288'(0));
        chk("rst_resp_out_valid", 288'(resp_out_valid), 288'(0));
        chk("rst_resp_out_data", resp_out_data, 288'(0));
        chk("rst_outstanding", 288'(outstanding), 288'(0));
        chk("rst_err", 288'(err_unexpected_resp), 288'(0));
        chk("rst_idle", 288'(idle), 288'(1));
    endtask

    // One clock: drive inputs, check the grant, queue expectations, then
    // check whatever the DUT produced against the scoreboard heads.
    task automatic step(input logic [3:0] v, input logic st, input logic fu,
                        input logic rv, input logic [287:0] rd,
                        input logic [3:0] exp_rdy, input int exp_out);
        int          gid;
        int          rid;
        logic [15:0] ea;
        logic [3:0]  ev;
        logic [287:0] ed;
        req_valid   = v;
        stall_issue = st;
        rdq_full    = fu;
        resp_valid  = rv;
        resp_data   = rd;
        #1;
        chk("req_ready", 288'(req_ready), 288'(exp_rdy));
        if (rv && id_q.size() > 0) begin
            rid = id_q.pop_front();
            resp_v_q.push_back(4'(1 << rid));
            resp_d_q.push_back(rd);
        end
        if (exp_rdy != 0) begin
            gid = 0;
            for (int i = 0; i < 4; i++) begin
                if (exp_rdy[i]) gid = i;
            end
            rdq_q.push_back(req_addr[gid*16 +: 16]);
            id_q.push_back(gid);
        end
        @(negedge clk);
        resp_valid = 1'b0;
        chk("rdq_we", 288'(rdq_we), 288'(rdq_q.size() != 0));
        if (rdq_we) begin
            ea = (rdq_q.size() > 0) ? rdq_q.pop_front() : 16'hxxxx;
            chk("rdq_data", 288'(rdq_data), 288'(ea));
        end
        if (resp_v_q.size() > 0) begin
            ev = resp_v_q.pop_front();
            ed = resp_d_q.pop_front();
            chk("resp_out_valid", 288'(resp_out_valid), 288'(ev));
            chk("resp_out_data", resp_out_data, ed);
        end else begin
            chk("resp_out_quiet", 288'(resp_out_valid), 288'(0));
        end
        if (exp_out >= 0) begin
            chk("outstanding", 288'(outstanding), 288'(exp_out));
        end
    endtask

    localparam logic [287:0] T_AB = {18{16'hABCD}};
    localparam logic [287:0] T_1  = {18{16'h1111}};
    localparam logic [287:0] T_2  = {18{16'h2222}};
    localparam logic [287:0] T_3  = {18{16'h3333}};
    localparam logic [287:0] T_4  = {18{16'h4444}};

    initial begin
        set_addr(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        do_reset();

        // Single requester round trip.
        set_addr(16'h0000, 16'h0000, 16'h1234, 16'h0000);
        step(4'b0100, 0, 0, 0, '0, 4'b0100, 1);
        step(4'b0000, 0, 0, 1, T_AB, 4'b0000, 0);
        chk("idle_after_rt", 288'(idle), 288'(1));

        // Fill credits with all requesters valid, then credit boundary.
        do_reset();
        set_addr(16'hA000, 16'hA001, 16'hA002, 16'hA003);
        step(4'b1111, 0, 0, 0, '0, 4'b0001, 1);
        step(4'b1111, 0, 0, 0, '0, 4'b0010, 2);
        step(4'b1111, 0, 0, 0, '0, 4'b0100, 3);
        step(4'b1111, 0, 0, 0, '0, 4'b1000, 4);
        step(4'b1111, 0, 0, 0, '0, 4'b0000, 4);
        step(4'b1111, 0, 0, 1, T_1, 4'b0000, 3);
        step(4'b1111, 0, 0, 0, '0, 4'b0001, 4);
        step(4'b0010, 0, 0, 1, T_2, 4'b0000, 3);
        step(4'b0010, 0, 0, 0, '0, 4'b0010, 4);
        step(4'b0000, 0, 0, 1, T_3, 4'b0000, 3);
        step(4'b0000, 0, 0, 1, T_4, 4'b0000, 2);
        step(4'b0000, 0, 0, 1, T_1, 4'b0000, 1);
        step(4'b0000, 0, 0, 1, T_2, 4'b0000, 0);
        chk("idle_after_drain", 288'(idle), 288'(1));

        // Out-of-index issue order routes responses back in issue order.
        do_reset();
        set_addr(16'h0000, 16'h0010, 16'h0020, 16'h0030);
        step(4'b1000, 0, 0, 0, '0, 4'b1000, 1);
        step(4'b0010, 0, 0, 0, '0, 4'b0010, 2);
        step(4'b0001, 0, 0, 0, '0, 4'b0001, 3);
        step(4'b0000, 0, 0, 1, T_1, 4'b0000, 2);
        step(4'b0000, 0, 0, 1, T_2, 4'b0000, 1);
        step(4'b0000, 0, 0, 1, T_3, 4'b0000, 0);

        // Stall and almost-full block grants while responses still flow.
        step(4'b1111, 0, 0, 0, '0, 4'b0010, 1);
        step(4'b1111, 1, 0, 0, '0, 4'b0000, 1);
        step(4'b1111, 1, 0, 1, T_4, 4'b0000, 0);
        step(4'b1111, 1, 0, 0, '0, 4'b0000, 0);
        chk("idle_in_stall", 288'(idle), 288'(1));
        step(4'b1111, 1, 0, 0, '0, 4'b0000, 0);
        step(4'b1111, 1, 0, 0, '0, 4'b0000, 0);
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 0, 1, 0, '0, 4'b0000, 0);
        end
        step(4'b1111, 0, 0, 0, '0, 4'b0100, 1);
        step(4'b1111, 0, 0, 1, T_AB, 4'b1000, 1);
        step(4'b0000, 0, 0, 1, T_1, 4'b0000, 0);

        // Response with nothing in flight.
        step(4'b0000, 0, 0, 1, T_2, 4'b0000, 0);
        chk("err_set", 288'(err_unexpected_resp), 288'(1));
        step(4'b0000, 0, 0, 0, '0, 4'b0000, 0);
        chk("err_sticky", 288'(err_unexpected_resp), 288'(1));
        do_reset();

        chk("sb_rdq_empty", 288'(rdq_q.size()), 288'(0));
        chk("sb_resp_empty", 288'(resp_v_q.size()), 288'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_read_scheduler.md
Name: dma_read_scheduler

Overview:
- Shares the DMA host-read path among N_REQ on-chip requesters, such as cache fill ports and the instruction fetcher.
- Round-robin arbitrates requests into the packet sender's read-request queue and caps outstanding reads at MAX_OUTSTANDING.
- Host read responses arrive in order from the packet receiver. Each one is routed back to the requester that issued it, using an in-order requester-ID FIFO.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_OUTSTANDING, 4, maximum reads in flight; also the ID FIFO depth (power of 2).
- ADDR_W, 16, host address width.
- TILE_W, 288, response payload width (18x16).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- stall_issue  in  1  when high, blocks new grants (used by end-program drain).
- req_valid  in  N_REQ  per-requester read request.
- req_addr  in  N_REQ*ADDR_W  per-requester host address; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_ready  out  N_REQ  one-hot grant; the request is accepted when valid & ready are both high.
- rdq_data  out  ADDR_W  address pushed to the read-request queue.
- rdq_we  out  1  read-request queue write strobe.
- rdq_full  in  1  queue has ≤1 free entry (almost-full semantics).
- resp_valid  in  1  one host read response, single-cycle pulse.
- resp_data  in  TILE_W  response tile.
- resp_out_valid  out  N_REQ  one-hot delivery pulse to the owning requester.
- resp_out_data  out  TILE_W  registered tile, broadcast to all requesters.
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  reads in flight.
- idle  out  1  outstanding==0 and no rdq_we pending.
- err_unexpected_resp  out  1  sticky: a response arrived with the ID FIFO empty.

Behaviour:
- Reset (reset==0 at a clk edge):
  - All outputs go to 0: req_ready, rdq_we, rdq_data, resp_out_valid, resp_out_data, outstanding, err_unexpected_resp. idle goes to 1.
  - The RR pointer resets to N_REQ-1, so requester 0 wins first.
  - ID FIFO pointers are cleared.
  - In-flight reads are forgotten; the host link is reset alongside.
- Grant condition in cycle t: any req_valid, and !stall_issue, and !rdq_full, and outstanding < MAX_OUTSTANDING.
  - At most one grant per cycle.
  - req_ready is combinational from the registered state and the current req_valid. It is the one-hot winner.
- Arbitration:
  - The winner is the first valid requester searching from (ptr+1) mod N_REQ upward with wrap.
  - On a grant, ptr <= winner.
  - With no grant, ptr holds.
- Issue latency:
  - Accepted at edge t → rdq_we=1 and rdq_data=winning address during cycle t+1.
  - The winner ID is pushed into the ID FIFO at the same edge.
  - Back-to-back grants are permitted every cycle.
- Response handling:
  - resp_valid at edge t → during cycle t+1, resp_out_valid[id]=1 and resp_out_data=resp_data, where id is the popped FIFO head.
  - resp_out_data holds until the next response.
- Credit arithmetic:
  - Grant only: outstanding+1.
  - Response only: outstanding-1.
  - Grant and response in the same cycle: outstanding unchanged. FIFO push and pop both occur; this is legal even when the FIFO is full, because the pop frees a slot.
  - outstanding == FIFO occupancy at all times.
- Boundary conditions:
  - When outstanding==MAX_OUTSTANDING, no grant occurs, even if a response arrives in that cycle. Credits are registered, so the freed credit is usable the next cycle.
  - FIFO pointers are log2(MAX_OUTSTANDING) bits and wrap naturally.
  - Response with the FIFO empty: the response is dropped, no resp_out_valid is asserted, err_unexpected_resp latches 1 until reset, and outstanding stays 0 (no underflow).
  - stall_issue rising mid-stream stops only new grants. Responses are still delivered, and idle rises once drained.
  - A requester dropping req_valid without a grant is legal. req_addr is sampled only in the grant cycle.

Decomposition:
- dma_pkg holds:
  - DMA_ADDR_W=16 and DMA_TILE_W=18*16.
  - The typedef dma_tile_t as logic [DMA_TILE_W-1:0].
  - The req_id_t width function.
- The sub-module dma_tag_fifo is a synchronous FIFO of requester IDs with simultaneous push/pop, count output and empty flag. It is reused later for write-ack tracking.
- The arbiter stays inline.

Test Plan:
- Reset, then requester 2 alone with addr 0x1234 → req_ready=0b0100 at t, rdq_we/rdq_data=0x1234 at t+1, outstanding=1. Response tile 0xAB.. → resp_out_valid=0b0100 at the next cycle, outstanding=0, idle=1.
- All 4 requesters valid continuously, no responses → grant order 0,1,2,3, then stall with outstanding=4. One response lets requester 0 win next (ptr=3).
- Issue order 3,1,0 (addresses 0x0030, 0x0010, 0x0000), then three responses → resp_out_valid pulses 0b1000, 0b0010, 0b0001 in that order with matching data.
- outstanding=4, and a response arrives in the same cycle requester 1 is valid → no grant in that cycle; grant to requester 1 next cycle; outstanding goes 4→3→4.
- rdq_full=1 or stall_issue=1 for 5 cycles with requests valid → no req_ready, no rdq_we; responses still delivered.
- resp_valid while idle → no resp_out_valid, err_unexpected_resp=1 and sticky, outstanding=0. A subsequent reset=0 clears it.
